mux_masters: RTL and testbench
==============================

# mux_masters

Two-master-to-one-slave request multiplexer for the crossbar. It sits on one slave port. An external arbiter supplies a one-hot grant. The block routes the granted master's request (req/addr/cmd/wdata) to the slave and returns slave ack/rdata only to that master. Optionally, it locks the grant for the duration of an outstanding transaction.

## Interface
Parameters:
- N, 32, address and data width.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst  input  1  reset; asynchronous, active-low.
- arb_master_req  input  2  one-hot grant from arbiter:
  - 2'b01 = master 1, 2'b10 = master 2.
  - 2'b00 and 2'b11 = no grant.
- master_1_req  input  1  master 1 request valid.
- master_1_addr  input  N  master 1 address.
- master_1_cmd  input  1  master 1 command: 0 read, 1 write.
- master_1_wdata  input  N  master 1 write data.
- master_2_req, master_2_addr, master_2_cmd, master_2_wdata  input  1/N/1/N  same for master 2.
- slave_ack  input  1  slave acknowledge; completes the current transaction.
- slave_rdata  input  N  slave read data.
- slave_req  output  1  forwarded request.
- slave_addr  output  N  forwarded address.
- slave_cmd  output  1  forwarded command.
- slave_wdata  output  N  forwarded write data.
- master_1_ack  output  1  ack to master 1.
- master_1_rdata  output  N  read data to master 1.
- master_2_ack, master_2_rdata  output  1/N  same for master 2.

## Operation
Effective select `sel`:
- With locking active and busy_q=1: sel = owner_q.
- Otherwise: sel = decode(arb_master_req).
- Values are M1, M2 or NONE. 2'b11 decodes to NONE.

Forward path (combinational):
- sel=M1: slave_req/addr/cmd/wdata = master_1_req/addr/cmd/wdata.
- sel=M2: the same signals from master 2.
- sel=NONE: all slave_* outputs = 0.

Return path (combinational):
- master_k_ack = slave_ack & (sel==Mk) & master_k_req.
- master_k_rdata = slave_rdata when sel==Mk, else 0.
- The non-selected master always sees ack=0 and rdata=0.

Lock state (busy_q, owner_q[1:0]):
- Idle, busy_q=0: if slave_req=1 and slave_ack=0 at a clock edge, set busy_q=1 and owner_q=sel.
- Busy, busy_q=1: clear busy_q when slave_ack=1 at a clock edge. Also clear it when the owner drops its req; the transaction is abandoned.
- Same-cycle req and ack (zero-wait transaction) never enters Busy.

While rst=0:
- busy_q=0 and owner_q=NONE.
- All outputs are forced to 0 regardless of inputs.

## Timing
- Forward and return paths: zero latency, purely combinational from inputs to outputs.
- Lock update: state changes only on the rising clk edge. Reset clears it immediately (asynchronous).
- Arbiter changes while Busy: ignored until the cycle after completion. The new grant takes effect combinationally once busy_q=0.
- Reset deasserted mid-transaction: the block restarts Idle and follows arb_master_req on the next evaluation.
- Ack arriving while sel=NONE: dropped, no master is acked.
- Ack arriving while the selected master's req=0: dropped, no master is acked.

## Configuration
- MUX_MASTERS_LOCK_EN defined:
  - busy_q/owner_q lock logic is compiled in.
  - The grant is held from request issue to slave_ack.
- Not defined:
  - No state; sel = decode(arb_master_req) at all times.
  - rst still forces outputs to 0.
  - Grant changes mid-transaction re-route immediately.

## Test plan
1. Reset: rst=0, all inputs non-zero, arb=2'b01 -> every output 0. Release rst -> slave_wdata=32'h11111111 follows master 1.
2. Select M1: arb=01, m1 req=1 cmd=0 addr=0, m2 wdata=32'hFFFFFFFF, slave_ack=1, slave_rdata=32'hFFFFFFFF ->
   - slave_req=1, slave_cmd=0, slave_wdata=32'h11111111.
   - master_1_ack=1, master_1_rdata=32'hFFFFFFFF.
   - master_2_ack=0, master_2_rdata=0.
3. Select M2: arb=10, m2 cmd=1 -> slave_cmd=1, slave_wdata=32'hFFFFFFFF, master_2_ack=slave_ack, master_1_rdata=0.
4. No grant: arb=00 and then arb=11 -> slave_* = 0, both acks 0, both rdata 0.
5. Lock (LOCK_EN): arb=01, m1 req=1, slave_ack=0 for 3 cycles; arb toggles to 10 in cycle 2 ->
   - Slave stays on master 1.
   - slave_ack=1 gives master_1_ack=1.
   - The cycle after, the slave follows master 2.
6. No lock (LOCK_EN undefined): same stimulus as scenario 5 -> slave outputs switch to master 2 in the same cycle arb changes.

Source files
------------

// File: rtl/mux_masters.sv
// mux_masters -- two-master to one-slave request multiplexer for one slave
// port of the crossbar. An external arbiter supplies a one-hot grant. The
// granted master's request is forwarded to the slave, and the slave's ack and
// read data are returned only to that master.
//
// Optional feature macro: MUX_MASTERS_LOCK_EN
//   defined   : the grant is locked from request issue until slave_ack (or
//               until the owner abandons its request).
//   undefined : purely combinational; grant changes re-route immediately.
//
// Lock states (MUX_MASTERS_LOCK_EN only):
//   state | meaning
//   IDLE  | no outstanding transaction, sel follows arb_master_req
//   BUSY  | transaction outstanding, sel held at owner_q
//
// Ports:
//   clk                 clock, rising edge
//   rst                 asynchronous active-low reset; forces every output to 0
//   arb_master_req[1:0] grant: 01 master 1, 10 master 2, 00/11 no grant
//   master_k_req/addr/cmd/wdata   request from master k (k = 1, 2)
//   slave_ack, slave_rdata        response from slave
//   slave_req/addr/cmd/wdata      forwarded request
//   master_k_ack, master_k_rdata  response routed back to master k
module mux_masters #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [1:0]   arb_master_req,
   input  logic         master_1_req,
   input  logic [N-1:0] master_1_addr,
   input  logic         master_1_cmd,
   input  logic [N-1:0] master_1_wdata,
   input  logic         master_2_req,
   input  logic [N-1:0] master_2_addr,
   input  logic         master_2_cmd,
   input  logic [N-1:0] master_2_wdata,
   input  logic         slave_ack,
   input  logic [N-1:0] slave_rdata,
   output logic         slave_req,
   output logic [N-1:0] slave_addr,
   output logic         slave_cmd,
   output logic [N-1:0] slave_wdata,
   output logic         master_1_ack,
   output logic [N-1:0] master_1_rdata,
   output logic         master_2_ack,
   output logic [N-1:0] master_2_rdata
);

   localparam logic [1:0] SEL_NONE = 2'b00;
   localparam logic [1:0] SEL_M1   = 2'b01;
   localparam logic [1:0] SEL_M2   = 2'b10;

   logic [1:0]   arb_sel;
   logic [1:0]   sel;
   logic         fwd_req;
   logic [N-1:0] fwd_addr;
   logic         fwd_cmd;
   logic [N-1:0] fwd_wdata;

   // 2'b11 is treated as no grant rather than a priority pick.
   always_comb begin
      arb_sel = SEL_NONE;
      case (arb_master_req)
         2'b01:   arb_sel = SEL_M1;
         2'b10:   arb_sel = SEL_M2;
         default: arb_sel = SEL_NONE;
      endcase
   end

`ifdef MUX_MASTERS_LOCK_EN
   localparam logic IDLE = 1'b0;
   localparam logic BUSY = 1'b1;

   logic       busy_q;
   logic       busy_d;
   logic [1:0] owner_q;
   logic [1:0] owner_d;

   assign sel = (busy_q == BUSY) ? owner_q : arb_sel;

   // While busy, fwd_req is the owner's own req, so !fwd_req means the owner
   // abandoned the transaction. A zero-wait transfer (req and ack together)
   // never enters BUSY.
   always_comb begin
      busy_d  = busy_q;
      owner_d = owner_q;
      if (busy_q == IDLE) begin
         if (fwd_req && !slave_ack) begin
            busy_d  = BUSY;
            owner_d = sel;
         end
      end else if (slave_ack || !fwd_req) begin
         busy_d  = IDLE;
         owner_d = SEL_NONE;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy_q  <= IDLE;
         owner_q <= SEL_NONE;
      end else begin
         busy_q  <= busy_d;
         owner_q <= owner_d;
      end
   end
`else
   // No state in this build; clk is only kept for a uniform port list.
   logic unused_clk;
   assign unused_clk = clk;
   assign sel        = arb_sel;
`endif

   always_comb begin
      fwd_req   = 1'b0;
      fwd_addr  = '0;
      fwd_cmd   = 1'b0;
      fwd_wdata = '0;
      case (sel)
         SEL_M1: begin
            fwd_req   = master_1_req;
            fwd_addr  = master_1_addr;
            fwd_cmd   = master_1_cmd;
            fwd_wdata = master_1_wdata;
         end
         SEL_M2: begin
            fwd_req   = master_2_req;
            fwd_addr  = master_2_addr;
            fwd_cmd   = master_2_cmd;
            fwd_wdata = master_2_wdata;
         end
         default: ;
      endcase
   end

   // Reset gates every output combinationally, independent of the inputs.
   always_comb begin
      slave_req      = 1'b0;
      slave_addr     = '0;
      slave_cmd      = 1'b0;
      slave_wdata    = '0;
      master_1_ack   = 1'b0;
      master_1_rdata = '0;
      master_2_ack   = 1'b0;
      master_2_rdata = '0;
      if (rst) begin
         slave_req   = fwd_req;
         slave_addr  = fwd_addr;
         slave_cmd   = fwd_cmd;
         slave_wdata = fwd_wdata;
         if (sel == SEL_M1) begin
            master_1_ack   = slave_ack & master_1_req;
            master_1_rdata = slave_rdata;
         end
         if (sel == SEL_M2) begin
            master_2_ack   = slave_ack & master_2_req;
            master_2_rdata = slave_rdata;
         end
      end
   end

endmodule

// File: tb/tb_mux_masters.sv
// Bench for mux_masters: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a behavioural model.
module tb_mux_masters;

   localparam int N = 32;

   logic         clk = 1'b0;
   logic         rst;
   logic [1:0]   arb;
   logic         m1_req, m1_cmd, m2_req, m2_cmd, s_ack;
   logic [N-1:0] m1_addr, m1_wdata, m2_addr, m2_wdata, s_rdata;
   logic         slave_req, slave_cmd, master_1_ack, master_2_ack;
   logic [N-1:0] slave_addr, slave_wdata, master_1_rdata, master_2_rdata;

   int checks = 0;
   int errors = 0;

   mux_masters #(.N(N)) dut (
      .clk(clk), .rst(rst), .arb_master_req(arb),
      .master_1_req(m1_req), .master_1_addr(m1_addr),
      .master_1_cmd(m1_cmd), .master_1_wdata(m1_wdata),
      .master_2_req(m2_req), .master_2_addr(m2_addr),
      .master_2_cmd(m2_cmd), .master_2_wdata(m2_wdata),
      .slave_ack(s_ack), .slave_rdata(s_rdata),
      .slave_req(slave_req), .slave_addr(slave_addr),
      .slave_cmd(slave_cmd), .slave_wdata(slave_wdata),
      .master_1_ack(master_1_ack), .master_1_rdata(master_1_rdata),
      .master_2_ack(master_2_ack), .master_2_rdata(master_2_rdata)
   );

   always #5 clk = ~clk;

`ifdef MUX_MASTERS_LOCK_EN
   localparam bit LOCK = 1'b1;
`else
   localparam bit LOCK = 1'b0;
`endif

   // Model state: which master (0 none, 1, 2) currently holds the slave.
   int m_owner = 0;

   typedef struct {
      logic         req;
      logic [N-1:0] addr;
      logic         cmd;
      logic [N-1:0] wdata;
      logic         ack1;
      logic [N-1:0] rd1;
      logic         ack2;
      logic [N-1:0] rd2;
   } exp_t;

   function automatic int who();
      if (LOCK && m_owner != 0) return m_owner;
      if (arb == 2'b01) return 1;
      if (arb == 2'b10) return 2;
      return 0;
   endfunction

   function automatic exp_t model();
      exp_t e;
      int   w;
      e = '{default: '0};
      w = who();
      if (rst !== 1'b1) return e;
      if (w == 1) begin
         e.req = m1_req; e.addr = m1_addr; e.cmd = m1_cmd; e.wdata = m1_wdata;
         e.ack1 = s_ack && m1_req; e.rd1 = s_rdata;
      end else if (w == 2) begin
         e.req = m2_req; e.addr = m2_addr; e.cmd = m2_cmd; e.wdata = m2_wdata;
         e.ack2 = s_ack && m2_req; e.rd2 = s_rdata;
      end
      return e;
   endfunction

   // A transaction is outstanding from an un-acked request until ack or until
   // the owner withdraws its request.
   always @(posedge clk or negedge rst) begin
      if (!rst) m_owner <= 0;
      else begin : upd
         exp_t e;
         int   w;
         e = model();
         w = who();
         if (m_owner == 0) begin
            if (e.req && !s_ack) m_owner <= w;
         end else if (s_ack || !e.req) m_owner <= 0;
      end
   end

   task automatic cmp(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Per-cycle comparison against the model, before the next rising edge.
   always @(negedge clk) begin
      #3;
      begin : chk
         exp_t e;
         e = model();
         cmp("slave_req",      N'(slave_req),    N'(e.req));
         cmp("slave_addr",     slave_addr,       e.addr);
         cmp("slave_cmd",      N'(slave_cmd),    N'(e.cmd));
         cmp("slave_wdata",    slave_wdata,      e.wdata);
         cmp("master_1_ack",   N'(master_1_ack), N'(e.ack1));
         cmp("master_1_rdata", master_1_rdata,   e.rd1);
         cmp("master_2_ack",   N'(master_2_ack), N'(e.ack2));
         cmp("master_2_rdata", master_2_rdata,   e.rd2);
      end
   end

   task automatic next_cycle();
      @(negedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      // Scenario 1: reset with all inputs non-zero.
      rst = 1'b0; arb = 2'b01;
      m1_req = 1; m1_cmd = 1; m1_addr = 32'hA1A1A1A1; m1_wdata = 32'h11111111;
      m2_req = 1; m2_cmd = 1; m2_addr = 32'hB2B2B2B2; m2_wdata = 32'hFFFFFFFF;
      s_ack = 1; s_rdata = 32'hCAFEF00D;
      next_cycle(); settle();
      cmp("rst_slave_req",   N'(slave_req), '0);
      cmp("rst_slave_wdata", slave_wdata,   '0);
      cmp("rst_m1_ack",      N'(master_1_ack), '0);
      cmp("rst_m1_rdata",    master_1_rdata, '0);
      cmp("rst_m2_rdata",    master_2_rdata, '0);
      next_cycle();
      rst = 1'b1; s_ack = 0; m1_req = 0; m2_req = 0;
      settle();
      cmp("post_rst_wdata", slave_wdata, 32'h11111111);

      // Scenario 2: master 1 selected, zero-wait read.
      next_cycle();
      arb = 2'b01; m1_req = 1; m1_cmd = 0; m1_addr = 0;
      m2_wdata = 32'hFFFFFFFF; s_ack = 1; s_rdata = 32'hFFFFFFFF;
      settle();
      cmp("m1_slave_req",   N'(slave_req), N'(1));
      cmp("m1_slave_cmd",   N'(slave_cmd), N'(0));
      cmp("m1_slave_wdata", slave_wdata, 32'h11111111);
      cmp("m1_ack",         N'(master_1_ack), N'(1));
      cmp("m1_rdata",       master_1_rdata, 32'hFFFFFFFF);
      cmp("m1_m2_ack",      N'(master_2_ack), N'(0));
      cmp("m1_m2_rdata",    master_2_rdata, '0);

      // Scenario 3: master 2 selected, zero-wait write.
      next_cycle();
      arb = 2'b10; m1_req = 0; m2_req = 1; m2_cmd = 1;
      settle();
      cmp("m2_slave_cmd",   N'(slave_cmd), N'(1));
      cmp("m2_slave_wdata", slave_wdata, 32'hFFFFFFFF);
      cmp("m2_ack",         N'(master_2_ack), N'(1));
      cmp("m2_m1_rdata",    master_1_rdata, '0);

      // Scenario 4: no grant (00 then 11), ack still asserted.
      next_cycle();
      arb = 2'b00; m1_req = 1;
      settle();
      cmp("arb00_slave_req", N'(slave_req), '0);
      cmp("arb00_wdata",     slave_wdata, '0);
      cmp("arb00_acks",      N'({master_1_ack, master_2_ack}), '0);
      next_cycle();
      arb = 2'b11;
      settle();
      cmp("arb11_addr",   slave_addr, '0);
      cmp("arb11_acks",   N'({master_1_ack, master_2_ack}), '0);
      cmp("arb11_rdata",  master_1_rdata | master_2_rdata, '0);

      // Scenario 5/6: grant changes while master 1 waits for ack.
      next_cycle();
      arb = 2'b00; m1_req = 0; m2_req = 0; s_ack = 0;
      next_cycle();
      arb = 2'b01; m1_req = 1; m2_req = 1;
      m1_addr = 32'h00001000; m2_addr = 32'h00002000;
      settle();
      cmp("lk_c1_addr", slave_addr, 32'h00001000);
      next_cycle();
      arb = 2'b10;
      settle();
      cmp("lk_c2_addr", slave_addr, LOCK ? 32'h00001000 : 32'h00002000);
      next_cycle();
      settle();
      cmp("lk_c3_addr", slave_addr, LOCK ? 32'h00001000 : 32'h00002000);
      next_cycle();
      s_ack = 1;
      settle();
      cmp("lk_ack_m1", N'(master_1_ack), LOCK ? N'(1) : N'(0));
      cmp("lk_ack_m2", N'(master_2_ack), LOCK ? N'(0) : N'(1));
      next_cycle();
      s_ack = 0;
      settle();
      cmp("lk_after_addr", slave_addr, 32'h00002000);
      next_cycle();
      m1_req = 0; m2_req = 0; arb = 2'b00;
      next_cycle();

      // Randomized traffic; the per-cycle compare process checks everything.
      for (int i = 0; i < 3000; i++) begin
         next_cycle();
         if ($urandom_range(99) < 2) rst = 1'b0;
         else if (rst == 1'b0 && $urandom_range(1) == 1) rst = 1'b1;
         if ($urandom_range(99) < 30) arb = 2'($urandom_range(3));
         if ($urandom_range(99) < 25) m1_req = ~m1_req;
         if ($urandom_range(99) < 25) m2_req = ~m2_req;
         m1_cmd = 1'($urandom_range(1)); m2_cmd = 1'($urandom_range(1));
         if ($urandom_range(3) == 0) begin
            m1_addr = $urandom; m2_addr = $urandom;
            m1_wdata = $urandom; m2_wdata = $urandom;
         end
         s_ack = ($urandom_range(99) < 30);
         s_rdata = $urandom;
         if (rst == 1'b1 && $urandom_range(99) < 3) begin
            #1 rst = 1'b0;
         end
      end

      next_cycle();
      #5;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
